// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM state encoding and default bus widths.
package apb_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state watchdog: counts stalled ACCESS cycles and flags the one in which the limit is hit.
// TIMEOUT_CYCLES = 0 disables the watchdog; expired_o then stays low.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned   CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit            ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST    = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count stalled cycles and saturate at the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The stalled cycle that would bring the count to the limit is the expiring one.
  assign expired_o = ENABLED && enable_i && (count_q >= LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one SETUP+ACCESS transfer per accepted command, one-cycle response strobe,
// with a wait-state watchdog aborting transfers to a stuck slave.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  mst_clk,
  input  logic                  mst_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e            state_q, state_d;
  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  wait_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (mst_clk),
    .rst_ni   (mst_rst_n),
    .clear_i  (state_q == APB_SETUP),
    .enable_i ((state_q == APB_ACCESS) && !pready),
    .expired_o(wait_expired)
  );

  // Next-state, request capture and response generation.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      APB_IDLE: begin
        if (cmd_valid && ready_q) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          state_d  = APB_SETUP;
        end
      end
      APB_SETUP: state_d = APB_ACCESS;
      APB_ACCESS: begin
        if (pready) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          state_d       = APB_IDLE;
        end else if (wait_expired) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = APB_IDLE;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  // State, request and response registers. cmd_ready is registered so it reads 0 during reset.
  always_ff @(posedge mst_clk or negedge mst_rst_n) begin
    if (!mst_rst_n) begin
      state_q       <= APB_IDLE;
      ready_q       <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= (state_d == APB_IDLE);
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign psel        = (state_q == APB_SETUP) || (state_q == APB_ACCESS);
  assign penable     = (state_q == APB_ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB slave with programmable waits/errors,
// transfer monitor, and a word-level reference memory predicting every response.
module tb_apb_master_bridge;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;

  // slave configuration for the current transfer (written by the stimulus only)
  int unsigned waits_cfg = 0;
  logic        err_cfg   = 1'b0;

  apb_master_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .mst_clk(clk), .mst_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // behavioural slave: pready after waits_cfg stalled ACCESS cycles
  logic [31:0] slv_mem [16] = '{default: '0};
  int unsigned slv_acc = 0;
  logic        in_access;

  assign in_access = psel && penable;
  assign pready    = in_access && (slv_acc == waits_cfg);
  assign pslverr   = in_access ? (pready && err_cfg) : err_cfg;
  assign prdata    = pready ? slv_mem[paddr[5:2]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (in_access && !pready) slv_acc <= slv_acc + 1;
    else                      slv_acc <= 0;
    if (in_access && pready && pwrite && !pslverr) slv_mem[paddr[5:2]] <= pwdata;
  end

  // transfer monitor: setup/access cycle counts and address/data stability
  logic        prev_psel = 1'b0;
  int unsigned mon_setup = 0, mon_acc = 0;
  logic [31:0] mon_addr = '0, mon_wdata = '0;
  logic        mon_unstable = 1'b0;

  always @(negedge clk) begin
    prev_psel <= psel;
    if (psel && !prev_psel) begin
      mon_setup    <= penable ? 0 : 1;
      mon_acc      <= 0;
      mon_addr     <= paddr;
      mon_wdata    <= pwdata;
      mon_unstable <= 1'b0;
    end else if (psel) begin
      if (!penable) mon_setup <= mon_setup + 1;
      else          mon_acc   <= mon_acc + 1;
      if (paddr !== mon_addr || pwdata !== mon_wdata) mon_unstable <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // reference memory, word-indexed like the slave
  logic [31:0] ref_mem [16] = '{default: '0};

  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int unsigned waits, input logic e);
    logic        tmo;
    logic [31:0] exp_rd;
    int unsigned exp_lat;
    int          n;
    tmo     = (waits >= TMO);
    exp_rd  = (tmo || w) ? 32'h0 : ref_mem[a[5:2]];
    exp_lat = tmo ? TMO + 1 : waits + 2;
    if (!tmo && w && !e) ref_mem[a[5:2]] = d;

    @(negedge clk);
    waits_cfg = waits;
    err_cfg   = e;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_bound", 64'(n < 20), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("setup_psel",    64'(psel),      64'd1);
    chk("setup_penable", 64'(penable),   64'd0);
    chk("setup_ready",   64'(cmd_ready), 64'd0);
    chk("setup_pwrite",  64'(pwrite),    64'(w));
    chk("setup_paddr",   64'(paddr),     64'(a));
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("rsp_latency", 64'(n),           64'(exp_lat));
    chk("rsp_rdata",   64'(rsp_rdata),   64'(exp_rd));
    chk("rsp_err",     64'(rsp_err),     64'(tmo | e));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(tmo));
    chk("rsp_psel",    64'(psel),        64'd0);
    chk("mon_setup",   64'(mon_setup),   64'd1);
    chk("mon_access",  64'(mon_acc),     64'(exp_lat - 1));
    chk("mon_stable",  64'(mon_unstable), 64'd0);
    chk("mon_addr",    64'(mon_addr),    64'(a));
    @(negedge clk);
    chk("rsp_pulse",   64'(rsp_valid),   64'd0);
    chk("rsp_hold",    64'(rsp_rdata),   64'(exp_rd));
    chk("idle_ready",  64'(cmd_ready),   64'd1);
    chk("idle_paddr",  64'(paddr),       64'(a));
  endtask

  initial begin : stim
    logic [31:0] bd [3];
    int          acc, rsps, cyc, last;
    logic        will;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    #12;
    chk("rst_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}, 64'd0);
    chk("rst_paddr",   64'(paddr),     64'd0);
    chk("rst_pwdata",  64'(pwdata),    64'd0);
    chk("rst_rdata",   64'(rsp_rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed write then read-back
    do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    do_cmd(1'b0, 32'h10, 32'h0, 1, 1'b0);
    // boundary: last wait that still completes, first wait that aborts, stuck slave
    do_cmd(1'b0, 32'h10, 32'h0, TMO - 1, 1'b0);
    do_cmd(1'b0, 32'h10, 32'h0, TMO, 1'b0);
    do_cmd(1'b1, 32'h20, 32'h12345678, 9, 1'b0);
    // slave error after 2 waits
    do_cmd(1'b0, 32'h10, 32'h0, 2, 1'b1);
    do_cmd(1'b1, 32'h24, 32'hCAFEF00D, 2, 1'b1);

    // cmd_valid held high across 3 commands
    waits_cfg = 0; err_cfg = 1'b0;
    for (int i = 0; i < 3; i++) bd[i] = $urandom;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = bd[0];
    acc = 0; rsps = 0; cyc = 0; last = 0;
    while (rsps < 3 && cyc < 60) begin
      will = cmd_valid && cmd_ready;
      if (psel) chk("b2b_ready_low", 64'(cmd_ready), 64'd0);
      if (rsp_valid) begin
        chk("b2b_rsp_err",   64'({rsp_err, rsp_timeout}), 64'd0);
        chk("b2b_rsp_rdata", 64'(rsp_rdata), 64'd0);
        rsps++;
      end
      @(negedge clk);
      cyc++;
      if (will) begin
        if (acc > 0) chk("b2b_spacing", 64'(cyc - last), 64'd3);
        last = cyc;
        acc++;
        if (acc < 3) begin
          cmd_addr  = 32'(acc + 1) << 2;
          cmd_wdata = bd[acc];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts", 64'(acc),  64'd3);
    chk("b2b_rsps",    64'(rsps), 64'd3);
    for (int i = 0; i < 3; i++) ref_mem[i + 1] = bd[i];
    for (int i = 0; i < 3; i++) do_cmd(1'b0, 32'(i + 1) << 2, 32'h0, 0, 1'b0);

    // reset during ACCESS
    @(negedge clk);
    waits_cfg = 6; err_cfg = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_penable", 64'(penable), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", {psel, penable, rsp_valid, cmd_ready}, 64'd0);
    for (int i = 0; i < 2; i++) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge clk);
    end
    do_cmd(1'b0, 32'h10, 32'h0, 0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [3:0] idx;
      idx = 4'($urandom_range(0, 15));
      do_cmd(1'($urandom_range(0, 1)), {26'd0, idx, 2'b00}, $urandom,
             $urandom_range(0, 6), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "simulation time limit");
  end

endmodule
